// File: rtl/shot_pkg.sv
// Shared types and helpers for the projectile scheduler.
// Screen size, FSM states, headings and the heading-to-sign lookup.
package shot_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPAWN,
    S_STEP
  } state_t;

  typedef enum logic [2:0] {
    DIR_N,
    DIR_NE,
    DIR_E,
    DIR_SE,
    DIR_S,
    DIR_SW,
    DIR_W,
    DIR_NW
  } dir_t;

  typedef struct packed {
    logic signed [1:0] sx;
    logic signed [1:0] sy;
  } sign_t;

  // Screen Y grows downward, so north is negative Y.
  function automatic sign_t dir_sign(input dir_t d);
    sign_t s;
    s.sx = 2'sd0;
    s.sy = 2'sd0;
    unique case (d)
      DIR_N:  begin s.sx = 2'sd0;  s.sy = -2'sd1; end
      DIR_NE: begin s.sx = 2'sd1;  s.sy = -2'sd1; end
      DIR_E:  begin s.sx = 2'sd1;  s.sy = 2'sd0;  end
      DIR_SE: begin s.sx = 2'sd1;  s.sy = 2'sd1;  end
      DIR_S:  begin s.sx = 2'sd0;  s.sy = 2'sd1;  end
      DIR_SW: begin s.sx = -2'sd1; s.sy = 2'sd1;  end
      DIR_W:  begin s.sx = -2'sd1; s.sy = 2'sd0;  end
      DIR_NW: begin s.sx = -2'sd1; s.sy = -2'sd1; end
      default: begin s.sx = 2'sd0; s.sy = 2'sd0; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings vsync into the Clk domain and emits one registered tick
// per rising edge, three Clk edges after the edge arrives.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic tick
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      tick <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/shot_scheduler.sv
// Per-frame projectile spawn and motion scheduler.
// Define SHOT_WRAP_EN for toroidal wrap with a per-shot lifetime.
module shot_scheduler
  import shot_pkg::*;
#(
  parameter int         NUM_SHOTS       = 4,
  parameter int         SHOT_SPEED      = 4,
  parameter int         COOLDOWN_FRAMES = 8,
  parameter logic [7:0] FIRE_KEY        = 8'h2C
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic [7:0]              keycode,
  input  logic [9:0]              ShipX,
  input  logic [9:0]              ShipY,
  input  logic [2:0]              ShipDir,
  output logic [NUM_SHOTS*10-1:0] ShotX,
  output logic [NUM_SHOTS*10-1:0] ShotY,
  output logic [NUM_SHOTS-1:0]    ShotActive,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int IW = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam int CW = (COOLDOWN_FRAMES > 0) ?
                      $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SHOTS - 1);
  localparam logic signed [10:0] SPD   = 11'(SHOT_SPEED);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);

  state_t state;
  state_t state_n;

  logic          tick;
  logic          pending;
  logic [IW-1:0] idx;
  logic [IW-1:0] spawn_slot;
  logic          spawn_vld;
  logic [CW-1:0] cooldown;

  logic [NUM_SHOTS-1:0] active;
  logic [9:0]           shot_x [NUM_SHOTS];
  logic [9:0]           shot_y [NUM_SHOTS];
  dir_t                 shot_dir [NUM_SHOTS];
`ifdef SHOT_WRAP_EN
  logic [5:0]           life [NUM_SHOTS];
  logic signed [10:0]   wx;
  logic signed [10:0]   wy;
`else
  logic                 off_screen;
`endif

  logic          fire_key;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          do_spawn;
  logic          hold_cd;
  logic          step_en;
  sign_t              sg;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] nx;
  logic signed [10:0] ny;

  frame_tick_sync u_sync (
    .Clk     (Clk),
    .Reset   (Reset),
    .async_in(frame_clk),
    .tick    (tick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (tick || pending) state_n = S_SPAWN;
      S_SPAWN: state_n = S_STEP;
      S_STEP:  if (idx == LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_STEP) && (idx == LAST);

  // One-deep backlog: a tick during an update is remembered once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending <= 1'b0;
      idx     <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (state_n == S_SPAWN) pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
      end
      if (state == S_SPAWN)     idx <= '0;
      else if (state == S_STEP) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign fire_key = (keycode == FIRE_KEY);
  assign do_spawn = (state == S_SPAWN) && fire_key &&
                    (cooldown == '0) && free_found;
  assign hold_cd  = fire_key && !free_found;
  assign step_en  = (state == S_STEP) && active[idx] &&
                    !(spawn_vld && (spawn_slot == idx));

  always_comb begin
    sg = dir_sign(shot_dir[idx]);
    unique case (sg.sx)
      2'b01:   dx = SPD;
      2'b11:   dx = -SPD;
      default: dx = '0;
    endcase
    unique case (sg.sy)
      2'b01:   dy = SPD;
      2'b11:   dy = -SPD;
      default: dy = '0;
    endcase
    nx = $signed({1'b0, shot_x[idx]}) + dx;
    ny = $signed({1'b0, shot_y[idx]}) + dy;
`ifdef SHOT_WRAP_EN
    if (nx[10])         wx = nx + 11'sd640;
    else if (nx > X_MAX) wx = nx - 11'sd640;
    else                wx = nx;
    if (ny[10])         wy = ny + 11'sd480;
    else if (ny > Y_MAX) wy = ny - 11'sd480;
    else                wy = ny;
`else
    off_screen = nx[10] || (nx > X_MAX) ||
                 ny[10] || (ny > Y_MAX);
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      active     <= '0;
      cooldown   <= '0;
      spawn_vld  <= 1'b0;
      spawn_slot <= '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        shot_x[i]   <= '0;
        shot_y[i]   <= '0;
        shot_dir[i] <= DIR_N;
`ifdef SHOT_WRAP_EN
        life[i]     <= '0;
`endif
      end
    end else begin
      if (state == S_SPAWN) begin
        if (do_spawn) begin
          active[free_idx]   <= 1'b1;
          shot_x[free_idx]   <= ShipX;
          shot_y[free_idx]   <= ShipY;
          shot_dir[free_idx] <= dir_t'(ShipDir);
`ifdef SHOT_WRAP_EN
          life[free_idx]     <= 6'd48;
`endif
          cooldown   <= CW'(COOLDOWN_FRAMES);
          spawn_vld  <= 1'b1;
          spawn_slot <= free_idx;
        end else begin
          spawn_vld <= 1'b0;
          if (!hold_cd && cooldown != '0)
            cooldown <= cooldown - 1'b1;
        end
      end
      if (step_en) begin
`ifdef SHOT_WRAP_EN
        shot_x[idx] <= wx[9:0];
        shot_y[idx] <= wy[9:0];
        life[idx]   <= life[idx] - 1'b1;
        if (life[idx] == 6'd1) active[idx] <= 1'b0;
`else
        if (off_screen) begin
          active[idx] <= 1'b0;
        end else begin
          shot_x[idx] <= nx[9:0];
          shot_y[idx] <= ny[9:0];
        end
`endif
      end
    end
  end

  always_comb begin
    ShotX = '0;
    ShotY = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      ShotX[i*10 +: 10] = shot_x[i];
      ShotY[i*10 +: 10] = shot_y[i];
    end
  end

  assign ShotActive = active;

endmodule

// File: tb/tb_shot_scheduler.sv
// Self-checking bench for shot_scheduler.
// Honors SHOT_WRAP_EN when it is defined for the DUT build.
module tb_shot_scheduler;

  typedef struct {
    bit         rst;
    logic [7:0] key;
    logic [9:0] sx;
    logic [9:0] sy;
    logic [2:0] dir;
    logic [3:0] act;
    logic [39:0] ex;
    logic [39:0] ey;
  } vec_t;

  typedef struct {
    string       name;
    logic [3:0]  act;
    logic [39:0] x;
    logic [39:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic [9:0]  ShipX = 10'd0;
  logic [9:0]  ShipY = 10'd0;
  logic [2:0]  ShipDir = 3'd0;
  logic [39:0] ShotX;
  logic [39:0] ShotY;
  logic [3:0]  ShotActive;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  vec_t vecs[9];

  always #10 clk = ~clk;

  shot_scheduler dut (
    .Clk       (clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .ShipX     (ShipX),
    .ShipY     (ShipY),
    .ShipDir   (ShipDir),
    .ShotX     (ShotX),
    .ShotY     (ShotY),
    .ShotActive(ShotActive),
    .busy      (busy),
    .frame_done(frame_done)
  );

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  function automatic logic [39:0] s0(input int v);
    logic [39:0] r;
    r = '0;
    r[9:0] = 10'(v);
    return r;
  endfunction

  task automatic run_frame(input exp_t e);
    bit ok;
    exp_t g;
    sb.push_back(e);
    ok = 1'b0;
    @(negedge clk);
    frame_clk = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    frame_clk = 1'b0;
    @(negedge clk);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: frame_done timeout", e.name);
    end
    if (sb.size() > 0) begin
      g = sb.pop_front();
      chk({g.name, ".act"}, 64'(ShotActive), 64'(g.act));
      chk({g.name, ".x"}, 64'(ShotX), 64'(g.x));
      chk({g.name, ".y"}, 64'(ShotY), 64'(g.y));
    end
  endtask

  initial begin
    exp_t e;
    int n;
    int dones;
    bit seen;
    int sp[4];
    sp[0] = 1; sp[1] = 10; sp[2] = 19; sp[3] = 28;

    vecs[0] = '{1, 8'h2C, 10'd320, 10'd240, 3'd0,
                4'b0001, s0(320), s0(240)};
    vecs[1] = '{0, 8'h00, 10'd0, 10'd0, 3'd0,
                4'b0001, s0(320), s0(236)};
    vecs[2] = '{0, 8'h2C, 10'd100, 10'd100, 3'd3,
                4'b0001, s0(320), s0(232)};
    vecs[3] = '{1, 8'h2C, 10'd638, 10'd100, 3'd2,
                4'b0001, s0(638), s0(100)};
    vecs[5] = '{1, 8'h2C, 10'd10, 10'd2, 3'd7,
                4'b0001, s0(10), s0(2)};
    vecs[7] = '{1, 8'h2C, 10'd5, 10'd479, 3'd5,
                4'b0001, s0(5), s0(479)};
`ifdef SHOT_WRAP_EN
    vecs[4] = '{0, 8'h00, 10'd0, 10'd0, 3'd0,
                4'b0001, s0(2), s0(100)};
    vecs[6] = '{0, 8'h00, 10'd0, 10'd0, 3'd0,
                4'b0001, s0(6), s0(478)};
    vecs[8] = '{0, 8'h00, 10'd0, 10'd0, 3'd0,
                4'b0001, s0(1), s0(3)};
`else
    vecs[4] = '{0, 8'h00, 10'd0, 10'd0, 3'd0,
                4'b0000, s0(638), s0(100)};
    vecs[6] = '{0, 8'h00, 10'd0, 10'd0, 3'd0,
                4'b0000, s0(10), s0(2)};
    vecs[8] = '{0, 8'h00, 10'd0, 10'd0, 3'd0,
                4'b0000, s0(5), s0(479)};
`endif

    repeat (3) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("rst.act", 64'(ShotActive), 64'd0);
    chk("rst.x", 64'(ShotX), 64'd0);
    chk("rst.y", 64'(ShotY), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(frame_done), 64'd0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      keycode = vecs[i].key;
      ShipX   = vecs[i].sx;
      ShipY   = vecs[i].sy;
      ShipDir = vecs[i].dir;
      e.name = $sformatf("vec%0d", i);
      e.act  = vecs[i].act;
      e.x    = vecs[i].ex;
      e.y    = vecs[i].ey;
      run_frame(e);
    end

    // Fire held: spawns at frames 1, 10, 19, 28, then slots full.
    do_reset();
    keycode = 8'h2C;
    ShipX = 10'd320;
    ShipY = 10'd240;
    ShipDir = 3'd4;
    for (int f = 1; f <= 30; f++) begin
      e.name = $sformatf("hold%0d", f);
      e.act = '0;
      e.x = '0;
      e.y = '0;
      for (int s = 0; s < 4; s++) begin
        if (f >= sp[s]) begin
          e.act[s] = 1'b1;
          e.x[s*10 +: 10] = 10'd320;
          e.y[s*10 +: 10] = 10'(240 + 4 * (f - sp[s]));
        end
      end
      run_frame(e);
      if (f >= 28)
        chk($sformatf("cd%0d", f), 64'(dut.cooldown), 64'd8);
    end

    // Ticks while busy: one extra update, a third edge dropped.
    do_reset();
    keycode = 8'h2C;
    ShipDir = 3'd4;
    e.name = "pend.spawn";
    e.act = 4'b0001;
    e.x = s0(320);
    e.y = s0(240);
    run_frame(e);
    keycode = 8'h00;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      frame_clk = (c == 0 || c == 2 || c == 4);
      if (frame_done) dones++;
    end
    chk("pend.count", 64'(dones), 64'd2);
    chk("pend.y", 64'(ShotY), 64'(s0(248)));
    chk("pend.busy", 64'(busy), 64'd0);

    // Reset during the second STEP cycle.
    do_reset();
    keycode = 8'h2C;
    e.name = "mid.spawn";
    e.act = 4'b0001;
    e.x = s0(320);
    e.y = s0(240);
    run_frame(e);
    keycode = 8'h00;
    @(negedge clk);
    frame_clk = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid.busy_seen", 64'(seen), 64'd1);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.act", 64'(ShotActive), 64'd0);
    chk("mid.x", 64'(ShotX), 64'd0);
    chk("mid.y", 64'(ShotY), 64'd0);
    chk("mid.busy", 64'(busy), 64'd0);
    chk("mid.done", 64'(frame_done), 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    frame_clk = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("mid.quiet", 64'(n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
